skew_feeder: RTL and testbench

- Self-sequencing operand feeder for the systolic array. It takes one `start` plus a latched tile config (base addresses, row count, active lane count).
- It issues the input and weight read-address streams to the unified buffer and absorbs the buffer read latency.
- It skews both return streams diagonally over a runtime-selectable number of lanes and generates aligned first/last markers.
- It drives a gated `compute_enable` that includes a propagation tail, then reports `done`. It sits between the unified buffer and the systolic array and replaces hand-driven address/marker sequencing.

---
 rtl/skew_feeder.sv | 172 +++++++++++++++++
 tb/tb_skew_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/skew_feeder.sv
// skew_feeder: issues one tile's input/weight read streams to the unified buffer and
// skews the returned rows diagonally onto the systolic array lanes, with first/last markers.
module skew_feeder #(
  parameter int  N          = 8,
  parameter int  DATA_WIDTH = 8,
  parameter int  ADDR_WIDTH = 10,
  parameter int  LEN_WIDTH  = 10,
  parameter int  RD_LATENCY = 1,
  localparam int LW         = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   cfg_input_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_weight_base,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [LW-1:0]           cfg_lanes,
  output logic                    ub_rd_en,
  output logic [ADDR_WIDTH-1:0]   ub_input_addr,
  output logic [ADDR_WIDTH-1:0]   ub_weight_addr,
  input  logic [N*DATA_WIDTH-1:0] ub_input_data,
  input  logic [N*DATA_WIDTH-1:0] ub_weight_data,
  output logic [N*DATA_WIDTH-1:0] input_skewed_flat,
  output logic [N*DATA_WIDTH-1:0] weight_skewed_flat,
  output logic                    first_out,
  output logic                    last_out,
  output logic                    compute_enable,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_error,
  output logic [1:0]              dbg_state
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] in_base_q, wt_base_q;
  logic [LEN_WIDTH-1:0]  len_q, idx_q, idx_d;
  logic [LW-1:0]         lanes_q, cnt_q, cnt_d;
  logic                  run_q, run_d, err_q, err_d;
  logic                  accept, cfg_ok, rd_en, last_sel;
  logic [2:0]            tag_in;
  logic [2:0]            tag_q [RD_LATENCY];
  logic                  first_q;
  logic [N-1:0]          last_q;

  assign cfg_ok = (cfg_len != '0) && (cfg_lanes != '0) && (cfg_lanes <= LW'(N));
  assign rd_en  = (state_q == S_ISSUE);
  // Tag bits: {valid, first row, last row}; they travel alongside the read latency.
  assign tag_in = {rd_en, rd_en && (idx_q == '0), rd_en && (idx_q == len_q - LEN_WIDTH'(1))};

  // The last row reaches lane lanes-1 after lanes-1 extra cycles of skew.
  always_comb begin
    last_sel = 1'b0;
    for (int i = 0; i < N; i++)
      if (lanes_q == LW'(i + 1)) last_sel = last_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst)     state_q <= S_IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept  = 1'b1;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        idx_d = idx_q + LEN_WIDTH'(1);
        if (idx_q == len_q - LEN_WIDTH'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Tail of lanes cycles lets the last row propagate through the array.
        if (last_sel) begin
          cnt_d = lanes_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (first_q) run_d = 1'b1;
    if (state_d == S_DONE) run_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_base_q <= '0;
      wt_base_q <= '0;
      len_q     <= '0;
      lanes_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= '0;
      for (int j = 0; j < RD_LATENCY; j++) tag_q[j] <= '0;
    end else if (en) begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      err_q <= err_d;
      if (accept) begin
        in_base_q <= cfg_input_base;
        wt_base_q <= cfg_weight_base;
        len_q     <= cfg_len;
        lanes_q   <= cfg_lanes;
      end
      tag_q[0] <= tag_in;
      for (int j = 1; j < RD_LATENCY; j++) tag_q[j] <= tag_q[j-1];
      first_q   <= tag_q[RD_LATENCY-1][1];
      last_q[0] <= tag_q[RD_LATENCY-1][0];
      for (int j = 1; j < N; j++) last_q[j] <= last_q[j-1];
    end
  end

  // Lane i: capture stage followed by i extra delay stages; inactive lanes and bubbles load 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] in_q [i+1];
    logic [DATA_WIDTH-1:0] wt_q [i+1];
    logic                  keep;

    assign keep = tag_q[RD_LATENCY-1][2] && (LW'(i) < lanes_q);

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          in_q[j] <= '0;
          wt_q[j] <= '0;
        end
      end else if (en) begin
        in_q[0] <= keep ? ub_input_data[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]  : '0;
        wt_q[0] <= keep ? ub_weight_data[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
        for (int j = 1; j <= i; j++) begin
          in_q[j] <= in_q[j-1];
          wt_q[j] <= wt_q[j-1];
        end
      end
    end

    assign input_skewed_flat[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]  = in_q[i];
    assign weight_skewed_flat[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] = wt_q[i];
  end

  assign ub_rd_en       = rd_en;
  assign ub_input_addr  = in_base_q + ADDR_WIDTH'(idx_q);
  assign ub_weight_addr = wt_base_q + ADDR_WIDTH'(idx_q);
  assign first_out      = first_q;
  assign last_out       = last_sel;
  assign compute_enable = en && (first_q || run_q);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign cfg_error      = err_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: drives tiles into skew_feeder with a latency-1 buffer model and checks
// every output each cycle against a timing/data model derived from the tile rules.
module tb_skew_feeder;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int LENW = 10;
  localparam int RL   = 1;
  localparam int LW   = $clog2(N + 1);
  localparam int FW   = N * DW;

  logic          clk = 1'b0;
  logic          rst, en, start;
  logic [AW-1:0] cfg_input_base, cfg_weight_base;
  logic [LENW-1:0] cfg_len;
  logic [LW-1:0] cfg_lanes;
  logic          ub_rd_en;
  logic [AW-1:0] ub_input_addr, ub_weight_addr;
  logic [FW-1:0] ub_input_data, ub_weight_data;
  logic [FW-1:0] input_skewed_flat, weight_skewed_flat;
  logic          first_out, last_out, compute_enable, busy, done, cfg_error;
  logic [1:0]    dbg_state;

  logic [FW-1:0] in_mem [1 << AW];
  logic [FW-1:0] wt_mem [1 << AW];
  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  skew_feeder #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LENW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .cfg_input_base(cfg_input_base), .cfg_weight_base(cfg_weight_base),
    .cfg_len(cfg_len), .cfg_lanes(cfg_lanes),
    .ub_rd_en(ub_rd_en), .ub_input_addr(ub_input_addr), .ub_weight_addr(ub_weight_addr),
    .ub_input_data(ub_input_data), .ub_weight_data(ub_weight_data),
    .input_skewed_flat(input_skewed_flat), .weight_skewed_flat(weight_skewed_flat),
    .first_out(first_out), .last_out(last_out), .compute_enable(compute_enable),
    .busy(busy), .done(done), .cfg_error(cfg_error), .dbg_state(dbg_state)
  );

  // Buffer model: one-cycle read latency, frozen together with the feeder by en.
  // Idle slots carry random junk so bubble masking is exercised.
  always @(posedge clk) begin
    if (en) begin
      if (ub_rd_en) begin
        ub_input_data  <= in_mem[ub_input_addr];
        ub_weight_data <= wt_mem[ub_weight_addr];
      end else begin
        ub_input_data  <= FW'($urandom);
        ub_weight_data <= FW'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Lane i shows row r = t-(RL+2)-i of the tile when that row exists and the lane is active.
  function automatic logic [FW-1:0] exp_flat(input bit wt, input int t, input int len,
                                             input int lanes, input int base);
    logic [FW-1:0] v;
    logic [FW-1:0] row;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int r;
      r = t - (RL + 2) - i;
      if (i < lanes && r >= 0 && r < len) begin
        row = wt ? wt_mem[(base + r) % (1 << AW)] : in_mem[(base + r) % (1 << AW)];
        v[i*DW +: DW] = row[i*DW +: DW];
      end
    end
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, ub_rd_en, 0);
    chk({tag, "_in_addr"}, ub_input_addr, 0);
    chk({tag, "_wt_addr"}, ub_weight_addr, 0);
    chk({tag, "_first"}, first_out, 0);
    chk({tag, "_last"}, last_out, 0);
    chk({tag, "_ce"}, compute_enable, 0);
    chk({tag, "_cfg_err"}, cfg_error, 0);
    chk({tag, "_in_flat"}, input_skewed_flat, 0);
    chk({tag, "_wt_flat"}, weight_skewed_flat, 0);
  endtask

  // One tile launched at cycle c=0; t counts enabled edges since the start edge.
  task automatic run_tile(input int len, input int lanes, input int ib, input int wb,
                          input int stall_at, input int stall_len, input int rst_at, input bit noise);
    int t, f, l, td, budget;
    logic [2*AW-1:0] e;
    logic [2*AW-1:0] exp_q [$];
    t  = 0;
    f  = RL + 2;
    l  = f + (len - 1) + (lanes - 1);
    td = l + lanes + 1;
    for (int k = 0; k < len; k++) exp_q.push_back({AW'(wb + k), AW'(ib + k)});
    budget = td + stall_len + 4;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (c == 0) begin
        cfg_len = LENW'(len); cfg_lanes = LW'(lanes);
        cfg_input_base = AW'(ib); cfg_weight_base = AW'(wb);
      end else if (noise) begin
        cfg_len = LENW'($urandom_range(0, 7)); cfg_lanes = LW'($urandom_range(0, 7));
        cfg_input_base = AW'($urandom); cfg_weight_base = AW'($urandom);
        if (t >= 1 && t <= td && $urandom_range(0, 2) == 0) start = 1'b1;
      end
      en  = !(c >= stall_at && c < stall_at + stall_len);
      rst = (c == rst_at);
      #1;
      chk("busy", busy, (t >= 1 && t <= td));
      chk("done", done, (t == td));
      chk("first_out", first_out, (t == f));
      chk("last_out", last_out, (t == l));
      chk("compute_enable", compute_enable, en && t >= f && t <= l + lanes);
      chk("cfg_error", cfg_error, 0);
      chk("input_flat", input_skewed_flat, exp_flat(1'b0, t, len, lanes, ib));
      chk("weight_flat", weight_skewed_flat, exp_flat(1'b1, t, len, lanes, wb));
      if (t >= 1 && t <= len) begin
        chk("rd_en", ub_rd_en, 1);
        chk("addr_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("input_addr", ub_input_addr, e[AW-1:0]);
          chk("weight_addr", ub_weight_addr, e[2*AW-1:AW]);
          if (en) void'(exp_q.pop_front());
        end
      end else begin
        chk("rd_en", ub_rd_en, 0);
      end
      if (c == rst_at) begin
        @(negedge clk);
        rst = 1'b0; start = 1'b0; en = 1'b1;
        #1;
        check_idle_zero("after_reset");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk); #1;
          chk("abort_no_done", done, 0);
          chk("abort_busy", busy, 0);
        end
        return;
      end
      if (en) t++;
    end
    start = 1'b0;
    chk("addr_q_drained", exp_q.size(), 0);
  endtask

  task automatic bad_cfg(input int len, input int lanes);
    @(negedge clk);
    start = 1'b1; en = 1'b1; cfg_len = LENW'(len); cfg_lanes = LW'(lanes);
    #1;
    chk("badcfg_err_before", cfg_error, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("badcfg_err_pulse", cfg_error, 1);
    chk("badcfg_busy", busy, 0);
    @(negedge clk); #1;
    chk("badcfg_err_clear", cfg_error, 0);
    chk("badcfg_busy_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0;
    cfg_len = '0; cfg_lanes = '0; cfg_input_base = '0; cfg_weight_base = '0;
    for (int a = 0; a < (1 << AW); a++) begin
      in_mem[a] = FW'($urandom);
      wt_mem[a] = FW'($urandom);
    end
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) in_mem[16 + r][i*DW +: DW] = DW'(r * 16 + i);
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // nominal tile with the 0x(r)(i) row pattern on the input side
    run_tile(3, 4, 'h10, 'h20, 1000, 0, -1, 1'b0);
    // partial lanes
    run_tile(2, 2, 'h40, 'h80, 1000, 0, -1, 1'b0);
    // stall for two cycles at T+2 with address wrap
    run_tile(2, 4, 'h3FF, 'h3FE, 2, 2, -1, 1'b0);
    // rejected configurations
    bad_cfg(0, 4);
    bad_cfg(3, 5);
    bad_cfg(3, 0);
    // starts and cfg changes while busy are ignored
    run_tile(3, 3, 'h100, 'h200, 1000, 0, -1, 1'b1);
    // smallest tile: first and last coincide
    run_tile(1, 1, 'h55, 'h66, 1000, 0, -1, 1'b0);
    // reset at T+4 aborts, then a nominal tile runs cleanly
    run_tile(3, 4, 'h10, 'h20, 1000, 0, 4, 1'b0);
    run_tile(3, 4, 'h10, 'h20, 1000, 0, -1, 1'b0);
    // randomized tiles
    for (int n = 0; n < 8; n++)
      run_tile($urandom_range(1, 8), $urandom_range(1, N), $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(1, 8), $urandom_range(0, 3), -1,
               1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
